cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
// Multicycle control FSM for the 16-bit single-bus CPU. Sequences fetch, decode and execute by driving datapath
// load/tristate/ALU/register-file/memory strobes. Waits on memory-function-complete (MFC). Samples the flag outputs.
// PARAMETERS
// none. Opcode, condition and state encodings are localparams taken from the shared package.
// PORTS
// clk    in  1   single clock, rising edge.
// rst    in  1   asynchronous, active-high reset.
// IRout  in  16  instruction register: [15:12] opcode, [11:9] dst/cond, [8:6] src, [8:0] branch offset.
// Sout,Vout,Zout,Cout  in 1 each  flag-register outputs: sign, overflow, zero, carry.
// MFC    in  1   memory function complete; level-sensitive.
// ldbuf,ldflags,ldPC,ld2,ldtemp,ldMAR,ldMDR,ldIR  out 1 each  register loads. ld2: R2<=R[dst]; ldbuf: ALU A<=bus.
// TPC,Tr2,Ttemp,TMAR,TMDR  out 1 each  tristate drives onto the internal bus. TMAR is never asserted.
// TMDR2X out 1   MDR drives the external memory data bus.
// add    out 1   force ALU ADD.
// transx out 1   force ALU pass-B. If neither add nor transx is set, the ALU decodes IR[15:12].
// rdR    out 1   R[src] onto bus.
// wR     out 1   bus into R[dst].
// rMDRi,rMDRX  out 1 each  MDR input select: memory / bus.
// sel1   out 2   ALU B: 00 bus, 01 +1, 10 sext(IR[8:0]), 11 zero.
// rd,wr  out 1 each  memory read/write requests.
// BEHAVIOUR
// - Moore FSM; outputs are decoded from state only. Every output not listed for a state is 0; sel1 defaults to 00.
// - rst high: state<=F0 immediately, all outputs forced to 0. Reset mid-instruction aborts the instruction.
// - F0: TPC,ldMAR,ldbuf.
// - F1: rd,rMDRi,ldMDR,add,sel1=01,ldtemp. Stays in F1 while MFC=0; goes to F2 when MFC=1.
// - F2: TMDR,ldIR.
// - F3: Ttemp,ldPC,ld2. Dispatches on IRout[15:12]:
//   0001-0101 ALU -> A0. 0110 MOV -> M0. 1000 LOAD -> L0. 1001 STORE -> S0. 1010 BR -> B0 if cond true, else F0.
//   1111 HALT -> H. All other opcodes (NOP) -> F0.
// - Branch cond IR[11:9]: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 S, 110 V, 111 S^V. Flags sampled in F3.
// - A0: Tr2,ldbuf. A1: rdR,ldtemp,ldflags (add=1 only for opcode 0001). A2: Ttemp,wR -> F0.
// - M0: rdR,transx,ldtemp. M1: Ttemp,wR -> F0.
// - L0: rdR,ldMAR. L1: rd,rMDRi,ldMDR; held while MFC=0. L2: TMDR,wR -> F0.
// - S0: rdR,ldMAR. S1: Tr2,rMDRX,ldMDR. S2: wr,TMDR2X; held while MFC=0; -> F0 on MFC=1.
// - B0: TPC,ldbuf. B1: add,sel1=10,ldtemp. B2: Ttemp,ldPC -> F0.
// - H: all outputs 0. Leaves H only on rst.
// - Unencoded state values recover to F0 on the next clock.
// - MFC is sampled only in F1, L1 and S2.
// - At most one bus driver (TPC/Tr2/Ttemp/TMDR/rdR) is active in any state.
// STRUCTURE
// - Package cpu_ctrl_pkg: state enum (F0..F3,A0..A2,M0,M1,L0..L2,S0..S2,B0..B2,H), opcode and cond localparams,
//   sel1 codes.
// - Single module: state register, next-state logic, output decode.
// - One natural sub-module: cond_eval (IR[11:9], S,V,Z,C -> taken).
// TESTING
// - Reset: rst=1 -> all outputs 0. Release -> F0 outputs TPC=ldMAR=ldbuf=1. Next cycle rd=1,add=1,sel1=01.
// - MFC=0 for 3 cycles in F1 -> rd held 4 cycles. MFC=1 -> F2 (TMDR,ldIR), then F3 (Ttemp,ldPC).
// - IRout=16'b1000000111001001 (LOAD), MFC=1 -> L0 rdR,ldMAR; L1 rd; L2 TMDR,wR; back to F0.
// - IRout=16'h1248 (ADD) -> A0 Tr2,ldbuf; A1 rdR,add,ldflags; A2 Ttemp,wR.
//   IRout=16'h9048 (STORE) -> S2 holds wr=1,TMDR2X=1 until MFC=1.
// - IRout=16'hA205 (BR Z): Zout=1 -> B0,B1 (sel1=10),B2 ldPC=1. Zout=0 -> F0 directly after F3.
// - IRout=16'hF000 -> H with all outputs 0 for 10 cycles. rst pulse in H or mid-L1 -> F0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, opcodes,
// branch conditions, ALU B-select codes and the control-strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_F0 = 5'd0,  ST_F1 = 5'd1,  ST_F2 = 5'd2,  ST_F3 = 5'd3,
        ST_A0 = 5'd4,  ST_A1 = 5'd5,  ST_A2 = 5'd6,
        ST_M0 = 5'd7,  ST_M1 = 5'd8,
        ST_L0 = 5'd9,  ST_L1 = 5'd10, ST_L2 = 5'd11,
        ST_S0 = 5'd12, ST_S1 = 5'd13, ST_S2 = 5'd14,
        ST_B0 = 5'd15, ST_B1 = 5'd16, ST_B2 = 5'd17,
        ST_H  = 5'd18
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_ALU_LO = 4'b0001;
    localparam logic [3:0] OP_ALU_HI = 4'b0101;
    localparam logic [3:0] OP_MOV    = 4'b0110;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_STORE  = 4'b1001;
    localparam logic [3:0] OP_BR     = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_Z      = 3'b001;
    localparam logic [2:0] CC_NZ     = 3'b010;
    localparam logic [2:0] CC_C      = 3'b011;
    localparam logic [2:0] CC_NC     = 3'b100;
    localparam logic [2:0] CC_S      = 3'b101;
    localparam logic [2:0] CC_V      = 3'b110;
    localparam logic [2:0] CC_LT     = 3'b111;

    localparam logic [1:0] SEL_BUS  = 2'b00;
    localparam logic [1:0] SEL_ONE  = 2'b01;
    localparam logic [1:0] SEL_OFFS = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef struct packed {
        logic       ldbuf, ldflags, ldpc, ld2, ldtemp, ldmar, ldmdr, ldir;
        logic       tpc, tr2, ttemp, tmar, tmdr, tmdr2x;
        logic       add, transx, rdr, wr_reg, rmdri, rmdrx;
        logic [1:0] sel1;
        logic       rd, wr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch-condition evaluator: maps IR[11:9] and the S/V/Z/C flags to "taken".
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       s,
    input  logic       v,
    input  logic       z,
    input  logic       c,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_ALWAYS: taken = 1'b1;
            CC_Z:      taken = z;
            CC_NZ:     taken = ~z;
            CC_C:      taken = c;
            CC_NC:     taken = ~c;
            CC_S:      taken = s;
            CC_V:      taken = v;
            CC_LT:     taken = s ^ v;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle Moore control FSM for the 16-bit single-bus CPU: fetch, decode
// and execute sequencing with MFC handshakes on memory cycles.
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IRout,
    input  logic        Sout,
    input  logic        Vout,
    input  logic        Zout,
    input  logic        Cout,
    input  logic        MFC,
    output logic        ldbuf,
    output logic        ldflags,
    output logic        ldPC,
    output logic        ld2,
    output logic        ldtemp,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        TPC,
    output logic        Tr2,
    output logic        Ttemp,
    output logic        TMAR,
    output logic        TMDR,
    output logic        TMDR2X,
    output logic        add,
    output logic        transx,
    output logic        rdR,
    output logic        wR,
    output logic        rMDRi,
    output logic        rMDRX,
    output logic [1:0]  sel1,
    output logic        rd,
    output logic        wr
);

    state_t     state, state_nxt;
    ctrl_t      ctl;
    logic [3:0] opcode;
    logic       br_taken;
    logic       unused_ir;

    assign opcode    = IRout[15:12];
    assign unused_ir = ^IRout[8:0];

    cond_eval u_cond (
        .cond  (IRout[11:9]),
        .s     (Sout),
        .v     (Vout),
        .z     (Zout),
        .c     (Cout),
        .taken (br_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_F0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_F0;
        case (state)
            ST_F0: state_nxt = ST_F1;
            ST_F1: state_nxt = MFC ? ST_F2 : ST_F1;
            ST_F2: state_nxt = ST_F3;
            ST_F3: begin
                if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) state_nxt = ST_A0;
                else if (opcode == OP_MOV)   state_nxt = ST_M0;
                else if (opcode == OP_LOAD)  state_nxt = ST_L0;
                else if (opcode == OP_STORE) state_nxt = ST_S0;
                else if (opcode == OP_BR)    state_nxt = br_taken ? ST_B0 : ST_F0;
                else if (opcode == OP_HALT)  state_nxt = ST_H;
                else                         state_nxt = ST_F0;
            end
            ST_A0: state_nxt = ST_A1;
            ST_A1: state_nxt = ST_A2;
            ST_M0: state_nxt = ST_M1;
            ST_L0: state_nxt = ST_L1;
            ST_L1: state_nxt = MFC ? ST_L2 : ST_L1;
            ST_S0: state_nxt = ST_S1;
            ST_S1: state_nxt = ST_S2;
            ST_S2: state_nxt = MFC ? ST_F0 : ST_S2;
            ST_B0: state_nxt = ST_B1;
            ST_B1: state_nxt = ST_B2;
            ST_H:  state_nxt = ST_H;
            default: state_nxt = ST_F0;
        endcase
    end

    // Outputs depend on state only (plus IR for the ADD strobe in A1); reset blanks them all.
    always_comb begin
        ctl = CTRL_IDLE;
        if (!rst) begin
            case (state)
                ST_F0: begin ctl.tpc = 1'b1; ctl.ldmar = 1'b1; ctl.ldbuf = 1'b1; end
                ST_F1: begin
                    ctl.rd = 1'b1; ctl.rmdri = 1'b1; ctl.ldmdr = 1'b1;
                    ctl.add = 1'b1; ctl.sel1 = SEL_ONE; ctl.ldtemp = 1'b1;
                end
                ST_F2: begin ctl.tmdr = 1'b1; ctl.ldir = 1'b1; end
                ST_F3: begin ctl.ttemp = 1'b1; ctl.ldpc = 1'b1; ctl.ld2 = 1'b1; end
                ST_A0: begin ctl.tr2 = 1'b1; ctl.ldbuf = 1'b1; end
                ST_A1: begin
                    ctl.rdr = 1'b1; ctl.ldtemp = 1'b1; ctl.ldflags = 1'b1;
                    ctl.add = (opcode == OP_ADD);
                end
                ST_A2: begin ctl.ttemp = 1'b1; ctl.wr_reg = 1'b1; end
                ST_M0: begin ctl.rdr = 1'b1; ctl.transx = 1'b1; ctl.ldtemp = 1'b1; end
                ST_M1: begin ctl.ttemp = 1'b1; ctl.wr_reg = 1'b1; end
                ST_L0: begin ctl.rdr = 1'b1; ctl.ldmar = 1'b1; end
                ST_L1: begin ctl.rd = 1'b1; ctl.rmdri = 1'b1; ctl.ldmdr = 1'b1; end
                ST_L2: begin ctl.tmdr = 1'b1; ctl.wr_reg = 1'b1; end
                ST_S0: begin ctl.rdr = 1'b1; ctl.ldmar = 1'b1; end
                ST_S1: begin ctl.tr2 = 1'b1; ctl.rmdrx = 1'b1; ctl.ldmdr = 1'b1; end
                ST_S2: begin ctl.wr = 1'b1; ctl.tmdr2x = 1'b1; end
                ST_B0: begin ctl.tpc = 1'b1; ctl.ldbuf = 1'b1; end
                ST_B1: begin ctl.add = 1'b1; ctl.sel1 = SEL_OFFS; ctl.ldtemp = 1'b1; end
                ST_B2: begin ctl.ttemp = 1'b1; ctl.ldpc = 1'b1; end
                default: ctl = CTRL_IDLE;
            endcase
        end
    end

    assign ldbuf   = ctl.ldbuf;
    assign ldflags = ctl.ldflags;
    assign ldPC    = ctl.ldpc;
    assign ld2     = ctl.ld2;
    assign ldtemp  = ctl.ldtemp;
    assign ldMAR   = ctl.ldmar;
    assign ldMDR   = ctl.ldmdr;
    assign ldIR    = ctl.ldir;
    assign TPC     = ctl.tpc;
    assign Tr2     = ctl.tr2;
    assign Ttemp   = ctl.ttemp;
    assign TMAR    = ctl.tmar;
    assign TMDR    = ctl.tmdr;
    assign TMDR2X  = ctl.tmdr2x;
    assign add     = ctl.add;
    assign transx  = ctl.transx;
    assign rdR     = ctl.rdr;
    assign wR      = ctl.wr_reg;
    assign rMDRi   = ctl.rmdri;
    assign rMDRX   = ctl.rmdrx;
    assign sel1    = ctl.sel1;
    assign rd      = ctl.rd;
    assign wr      = ctl.wr;

endmodule

// File: tb/tb_cpu_controller.sv
// Cycle-by-cycle vector bench for cpu_controller; expected strobe sets are
// queued when each cycle's inputs are driven and checked mid-cycle.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] IRout = '0;
    logic        Sout = 1'b0, Vout = 1'b0, Zout = 1'b0, Cout = 1'b0;
    logic        MFC = 1'b0;
    logic        ldbuf, ldflags, ldPC, ld2, ldtemp, ldMAR, ldMDR, ldIR;
    logic        TPC, Tr2, Ttemp, TMAR, TMDR, TMDR2X;
    logic        add, transx, rdR, wR, rMDRi, rMDRX, rd, wr;
    logic [1:0]  sel1;

    cpu_controller dut (
        .clk(clk), .rst(rst), .IRout(IRout),
        .Sout(Sout), .Vout(Vout), .Zout(Zout), .Cout(Cout), .MFC(MFC),
        .ldbuf(ldbuf), .ldflags(ldflags), .ldPC(ldPC), .ld2(ld2), .ldtemp(ldtemp),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR),
        .TPC(TPC), .Tr2(Tr2), .Ttemp(Ttemp), .TMAR(TMAR), .TMDR(TMDR), .TMDR2X(TMDR2X),
        .add(add), .transx(transx), .rdR(rdR), .wR(wR), .rMDRi(rMDRi), .rMDRX(rMDRX),
        .sel1(sel1), .rd(rd), .wr(wr)
    );

    always #5 clk = ~clk;

    logic [23:0] obs;
    assign obs = {ldbuf, ldflags, ldPC, ld2, ldtemp, ldMAR, ldMDR, ldIR,
                  TPC, Tr2, Ttemp, TMAR, TMDR, TMDR2X,
                  add, transx, rdR, wR, rMDRi, rMDRX, sel1, rd, wr};

    localparam logic [23:0] B_LDBUF  = 24'h800000, B_LDFLAGS = 24'h400000;
    localparam logic [23:0] B_LDPC   = 24'h200000, B_LD2     = 24'h100000;
    localparam logic [23:0] B_LDTEMP = 24'h080000, B_LDMAR   = 24'h040000;
    localparam logic [23:0] B_LDMDR  = 24'h020000, B_LDIR    = 24'h010000;
    localparam logic [23:0] B_TPC    = 24'h008000, B_TR2     = 24'h004000;
    localparam logic [23:0] B_TTEMP  = 24'h002000, B_TMDR    = 24'h000800;
    localparam logic [23:0] B_TMDR2X = 24'h000400, B_ADD     = 24'h000200;
    localparam logic [23:0] B_TRANSX = 24'h000100, B_RDR     = 24'h000080;
    localparam logic [23:0] B_WR_R   = 24'h000040, B_RMDRI   = 24'h000020;
    localparam logic [23:0] B_RMDRX  = 24'h000010, B_SEL01   = 24'h000004;
    localparam logic [23:0] B_SEL10  = 24'h000008, B_RD      = 24'h000002;
    localparam logic [23:0] B_WR     = 24'h000001;

    localparam logic [23:0] E_ZERO = 24'h0;
    localparam logic [23:0] E_F0  = B_TPC | B_LDMAR | B_LDBUF;
    localparam logic [23:0] E_F1  = B_RD | B_RMDRI | B_LDMDR | B_ADD | B_SEL01 | B_LDTEMP;
    localparam logic [23:0] E_F2  = B_TMDR | B_LDIR;
    localparam logic [23:0] E_F3  = B_TTEMP | B_LDPC | B_LD2;
    localparam logic [23:0] E_A0  = B_TR2 | B_LDBUF;
    localparam logic [23:0] E_A1  = B_RDR | B_LDTEMP | B_LDFLAGS;
    localparam logic [23:0] E_A2  = B_TTEMP | B_WR_R;
    localparam logic [23:0] E_M0  = B_RDR | B_TRANSX | B_LDTEMP;
    localparam logic [23:0] E_L0  = B_RDR | B_LDMAR;
    localparam logic [23:0] E_L1  = B_RD | B_RMDRI | B_LDMDR;
    localparam logic [23:0] E_L2  = B_TMDR | B_WR_R;
    localparam logic [23:0] E_S1  = B_TR2 | B_RMDRX | B_LDMDR;
    localparam logic [23:0] E_S2  = B_WR | B_TMDR2X;
    localparam logic [23:0] E_B0  = B_TPC | B_LDBUF;
    localparam logic [23:0] E_B1  = B_ADD | B_SEL10 | B_LDTEMP;
    localparam logic [23:0] E_B2  = B_TTEMP | B_LDPC;

    typedef struct {
        string       nm;
        logic        rst;
        logic        mfc;
        logic [15:0] ir;
        logic [3:0]  fl;   // {S,V,Z,C}
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        int          idx;
        logic [23:0] exp;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    logic [15:0] cir = '0;
    logic [3:0]  cfl = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic row(input string nm, input logic r, input logic m, input logic [23:0] e);
        vec_t v;
        v.nm = nm; v.rst = r; v.mfc = m; v.ir = cir; v.fl = cfl; v.exp = e;
        vecs.push_back(v);
    endtask

    // Standard fetch with MFC answered immediately; F3 carries the given flags.
    task automatic fetch(input string nm, input logic [15:0] ir, input logic [3:0] fl);
        cir = ir; cfl = 4'h0;
        row({nm, "_F0"}, 1'b0, 1'b0, E_F0);
        row({nm, "_F1"}, 1'b0, 1'b1, E_F1);
        row({nm, "_F2"}, 1'b0, 1'b0, E_F2);
        cfl = fl;
        row({nm, "_F3"}, 1'b0, 1'b0, E_F3);
        cfl = 4'h0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t x;
            x = sb.pop_front();
            checks++;
            if (obs !== x.exp) begin
                failures++;
                $display("FAIL %s row=%0d got=%06h exp=%06h", x.nm, x.idx, obs, x.exp);
            end
        end
    end

    initial begin
        // Reset and first fetch with a slow memory (MFC low three cycles).
        cir = 16'h81C9;
        row("rst_a", 1'b1, 1'b0, E_ZERO);
        row("rst_b", 1'b1, 1'b0, E_ZERO);
        row("rel_F0", 1'b0, 1'b0, E_F0);
        row("F1_w0", 1'b0, 1'b0, E_F1);
        row("F1_w1", 1'b0, 1'b0, E_F1);
        row("F1_w2", 1'b0, 1'b0, E_F1);
        row("F1_go", 1'b0, 1'b1, E_F1);
        row("F2", 1'b0, 1'b0, E_F2);
        row("F3", 1'b0, 1'b0, E_F3);
        // LOAD with one wait state in L1.
        row("L0", 1'b0, 1'b0, E_L0);
        row("L1_w", 1'b0, 1'b0, E_L1);
        row("L1_go", 1'b0, 1'b1, E_L1);
        row("L2", 1'b0, 1'b0, E_L2);
        // ADD.
        fetch("add", 16'h1248, 4'h0);
        row("A0", 1'b0, 1'b0, E_A0);
        row("A1_add", 1'b0, 1'b0, E_A1 | B_ADD);
        row("A2", 1'b0, 1'b0, E_A2);
        // STORE with S2 held two cycles.
        fetch("st", 16'h9048, 4'h0);
        row("S0", 1'b0, 1'b0, E_L0);
        row("S1", 1'b0, 1'b0, E_S1);
        row("S2_w0", 1'b0, 1'b0, E_S2);
        row("S2_w1", 1'b0, 1'b0, E_S2);
        row("S2_go", 1'b0, 1'b1, E_S2);
        // BR Z taken, then not taken.
        fetch("brz_t", 16'hA205, 4'b0010);
        row("B0", 1'b0, 1'b0, E_B0);
        row("B1", 1'b0, 1'b0, E_B1);
        row("B2", 1'b0, 1'b0, E_B2);
        fetch("brz_n", 16'hA205, 4'b1101);
        // BR S^V taken (S=1,V=0) and BR C not taken.
        fetch("brlt_t", 16'hAE05, 4'b1000);
        row("lt_B0", 1'b0, 1'b0, E_B0);
        row("lt_B1", 1'b0, 1'b0, E_B1);
        row("lt_B2", 1'b0, 1'b0, E_B2);
        fetch("brc_n", 16'hA605, 4'b1110);
        // MOV, SUB (no forced add), NOP.
        fetch("mov", 16'h6248, 4'h0);
        row("M0", 1'b0, 1'b0, E_M0);
        row("M1", 1'b0, 1'b0, E_A2);
        fetch("sub", 16'h2248, 4'h0);
        row("sA0", 1'b0, 1'b0, E_A0);
        row("sA1", 1'b0, 1'b0, E_A1);
        row("sA2", 1'b0, 1'b0, E_A2);
        fetch("nop", 16'h0000, 4'h0);
        // HALT: idle for 10 cycles regardless of MFC, then reset out of it.
        fetch("halt", 16'hF000, 4'h0);
        for (int i = 0; i < 10; i++) row("H", 1'b0, i[0], E_ZERO);
        row("H_rst", 1'b1, 1'b0, E_ZERO);
        // Reset while LOAD is waiting in L1.
        fetch("ldab", 16'h81C9, 4'h0);
        row("ab_L0", 1'b0, 1'b0, E_L0);
        row("ab_L1", 1'b0, 1'b0, E_L1);
        row("ab_rst", 1'b1, 1'b0, E_ZERO);
        row("ab_F0", 1'b0, 1'b0, E_F0);
        row("ab_F1", 1'b0, 1'b0, E_F1);

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t s;
            @(posedge clk);
            #1;
            rst   = vecs[i].rst;
            MFC   = vecs[i].mfc;
            IRout = vecs[i].ir;
            {Sout, Vout, Zout, Cout} = vecs[i].fl;
            s.nm = vecs[i].nm; s.idx = i; s.exp = vecs[i].exp;
            sb.push_back(s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
